// File: rtl/sprite_compositor_pkg.sv
// sprite_compositor_pkg: shared colour type, key colour and default geometry for the compositor.
package sprite_compositor_pkg;
  localparam int COLOR_W = 12;
  typedef logic [COLOR_W-1:0] color_t;
  localparam color_t DEF_KEY_COLOR = 12'hA0A;
  localparam int DEF_PIX_W = 10;
  localparam int DEF_NUM_SPRITES = 4;
  localparam int DEF_SPR_W = 14;
  localparam int DEF_SPR_H = 16;
  localparam int DEF_SPR_AW = 8;
  localparam int DEF_BG_X = 200;
  localparam int DEF_BG_Y = 150;
  localparam int DEF_BG_W = 160;
  localparam int DEF_BG_H = 240;
  localparam int DEF_BG_AW = 16;
  localparam int DEF_SCROLL_DIV = 500000;
  function automatic logic opaque(input color_t c, input color_t key);
    return c != key;
  endfunction
endpackage

// File: rtl/sprite_compositor_hit_unit.sv
// sprite_hit_unit: per-sprite frame-shadowed position, hit test, ROM address and hit delay.
module sprite_hit_unit
  import sprite_compositor_pkg::*;
#(
  parameter int PIX_W  = DEF_PIX_W,
  parameter int SPR_W  = DEF_SPR_W,
  parameter int SPR_H  = DEF_SPR_H,
  parameter int SPR_AW = DEF_SPR_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_frame_start,
  input  logic [PIX_W-1:0]  i_x,
  input  logic [PIX_W-1:0]  i_y,
  input  logic              i_en,
  input  logic [PIX_W-1:0]  i_hor,
  input  logic [PIX_W-1:0]  i_ver,
  output logic [SPR_AW-1:0] o_addr,
  output logic              o_hit
);
  logic [PIX_W-1:0]  r_x, r_y;
  logic              r_en, r_hit, r_hit_d;
  logic [SPR_AW-1:0] r_addr;
  logic [PIX_W-1:0]  w_dx, w_dy;
  logic              w_hit;
  assign w_dx = i_hor - r_x;
  assign w_dy = i_ver - r_y;
  // one extra bit keeps x+SPR_W from wrapping near the screen edge
  assign w_hit = r_en && i_hor >= r_x && {1'b0, i_hor} < {1'b0, r_x} + (PIX_W+1)'(SPR_W)
              && i_ver >= r_y && {1'b0, i_ver} < {1'b0, r_y} + (PIX_W+1)'(SPR_H);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x     <= '0;
      r_y     <= '0;
      r_en    <= 1'b0;
      r_hit   <= 1'b0;
      r_hit_d <= 1'b0;
      r_addr  <= '0;
    end else begin
      if (i_frame_start) begin
        r_x  <= i_x;
        r_y  <= i_y;
        r_en <= i_en;
      end
      r_hit   <= w_hit;
      r_hit_d <= r_hit;
      r_addr  <= SPR_AW'(w_dy) * SPR_AW'(SPR_W) + SPR_AW'(w_dx);
    end
  end
  assign o_addr = r_addr;
  assign o_hit  = r_hit_d;
endmodule

// File: rtl/sprite_compositor.sv
// sprite_compositor: scrolling background plus keyed priority sprites into one RGB stream,
// with sticky per-frame collision flags between sprite 0 and every other sprite.
module sprite_compositor
  import sprite_compositor_pkg::*;
#(
  parameter int     PIX_W       = DEF_PIX_W,
  parameter int     NUM_SPRITES = DEF_NUM_SPRITES,
  parameter int     SPR_W       = DEF_SPR_W,
  parameter int     SPR_H       = DEF_SPR_H,
  parameter int     SPR_AW      = DEF_SPR_AW,
  parameter int     BG_X        = DEF_BG_X,
  parameter int     BG_Y        = DEF_BG_Y,
  parameter int     BG_W        = DEF_BG_W,
  parameter int     BG_H        = DEF_BG_H,
  parameter int     BG_AW       = DEF_BG_AW,
  parameter color_t KEY_COLOR   = DEF_KEY_COLOR,
  parameter int     SCROLL_DIV  = DEF_SCROLL_DIV
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PIX_W-1:0]              i_hor_pix,
  input  logic [PIX_W-1:0]              i_ver_pix,
  input  logic                          i_frame_start,
  input  logic [NUM_SPRITES*PIX_W-1:0]  i_spr_x,
  input  logic [NUM_SPRITES*PIX_W-1:0]  i_spr_y,
  input  logic [NUM_SPRITES-1:0]        i_spr_en,
  input  logic                          i_scroll_en,
  output logic [NUM_SPRITES*SPR_AW-1:0] o_spr_addr,
  input  logic [NUM_SPRITES*COLOR_W-1:0] i_spr_color,
  output logic [BG_AW-1:0]              o_bg_addr,
  input  logic [COLOR_W-1:0]            i_bg_color,
  output logic [COLOR_W-1:0]            o_rgb,
  output logic [NUM_SPRITES-2:0]        o_collide,
  output logic [PIX_W-1:0]              o_bg_offset
);
  localparam int DIV_W = $clog2(SCROLL_DIV + 1);
  logic [NUM_SPRITES-1:0] w_hit, w_opq;
  logic [NUM_SPRITES-2:0] w_coll, r_acc, r_collide;
  logic                   r_bg_hit, r_bg_hit_d, w_bg_hit, w_tc;
  logic [BG_AW-1:0]       r_bg_addr, w_bg_addr;
  logic [PIX_W:0]         w_row_raw, w_row;
  logic [PIX_W-1:0]       r_offset;
  logic [DIV_W-1:0]       r_div;
  color_t                 r_rgb, w_mux;
  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_spr
    sprite_hit_unit #(.PIX_W(PIX_W), .SPR_W(SPR_W), .SPR_H(SPR_H), .SPR_AW(SPR_AW)) u_hit (
      .clk(clk),
      .rst(rst),
      .i_frame_start(i_frame_start),
      .i_x(i_spr_x[g*PIX_W +: PIX_W]),
      .i_y(i_spr_y[g*PIX_W +: PIX_W]),
      .i_en(i_spr_en[g]),
      .i_hor(i_hor_pix),
      .i_ver(i_ver_pix),
      .o_addr(o_spr_addr[g*SPR_AW +: SPR_AW]),
      .o_hit(w_hit[g])
    );
    assign w_opq[g] = w_hit[g] && opaque(i_spr_color[g*COLOR_W +: COLOR_W], KEY_COLOR);
    if (g > 0) begin : g_coll
      assign w_coll[g-1] = w_opq[0] && w_opq[g];
    end
  end
  assign w_bg_hit = i_hor_pix >= PIX_W'(BG_X) && {1'b0, i_hor_pix} < (PIX_W+1)'(BG_X + BG_W)
                 && i_ver_pix >= PIX_W'(BG_Y) && {1'b0, i_ver_pix} < (PIX_W+1)'(BG_Y + BG_H);
  // offset < BG_H, so one conditional subtract is enough to wrap the row
  assign w_row_raw = {1'b0, i_ver_pix - PIX_W'(BG_Y)} + {1'b0, r_offset};
  assign w_row     = w_row_raw >= (PIX_W+1)'(BG_H) ? w_row_raw - (PIX_W+1)'(BG_H) : w_row_raw;
  assign w_bg_addr = BG_AW'(i_hor_pix - PIX_W'(BG_X)) + BG_AW'(w_row) * BG_AW'(BG_W);
  assign w_tc      = r_div == DIV_W'(SCROLL_DIV - 1);
  always_comb begin
    w_mux = r_bg_hit_d ? i_bg_color : '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--)
      w_mux = w_opq[i] ? i_spr_color[i*COLOR_W +: COLOR_W] : w_mux;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div      <= '0;
      r_offset   <= '0;
      r_bg_hit   <= 1'b0;
      r_bg_hit_d <= 1'b0;
      r_bg_addr  <= '0;
      r_rgb      <= '0;
      r_acc      <= '0;
      r_collide  <= '0;
    end else begin
      r_div <= w_tc ? '0 : r_div + 1'b1;
      if (w_tc && i_scroll_en)
        r_offset <= r_offset == '0 ? PIX_W'(BG_H - 1) : r_offset - 1'b1;
      r_bg_hit   <= w_bg_hit;
      r_bg_hit_d <= r_bg_hit;
      r_bg_addr  <= w_bg_addr;
      r_rgb      <= w_mux;
      r_acc      <= i_frame_start ? '0 : r_acc | w_coll;
      if (i_frame_start)
        r_collide <= r_acc | w_coll;
    end
  end
  assign o_bg_addr   = r_bg_addr;
  assign o_rgb       = r_rgb;
  assign o_collide   = r_collide;
  assign o_bg_offset = r_offset;
endmodule

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor: directed and randomized checks of the compositor against a pixel-level model.
module tb_sprite_compositor;
  localparam int N = 4;
  localparam int PW = 10;
  localparam int AW = 8;
  localparam int BAW = 16;
  localparam logic [11:0] KEY = 12'hA0A;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [PW-1:0] hor, ver, bg_offset;
  logic frame_start, scroll_en;
  logic [N*PW-1:0] spr_x, spr_y;
  logic [N-1:0] spr_en;
  logic [N*AW-1:0] spr_addr;
  logic [N*12-1:0] spr_color;
  logic [BAW-1:0] bg_addr;
  logic [11:0] bg_color, rgb;
  logic [N-2:0] collide;
  int checks = 0;
  int fails = 0;
  logic [11:0] spr_rom [N][256];
  int sh_x[N], sh_y[N];
  bit sh_en[N];
  int off, cyc;
  logic [N-2:0] acc, mcol;
  logic [11:0] q[$];

  always #5 clk = ~clk;

  sprite_compositor #(.SCROLL_DIV(4)) dut (
    .clk(clk), .rst(rst), .i_hor_pix(hor), .i_ver_pix(ver), .i_frame_start(frame_start),
    .i_spr_x(spr_x), .i_spr_y(spr_y), .i_spr_en(spr_en), .i_scroll_en(scroll_en),
    .o_spr_addr(spr_addr), .i_spr_color(spr_color), .o_bg_addr(bg_addr), .i_bg_color(bg_color),
    .o_rgb(rgb), .o_collide(collide), .o_bg_offset(bg_offset)
  );

  function automatic logic [11:0] bg_rom(input int a);
    return 12'((a * 7 + 3) ^ (a >> 5));
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) spr_color[i*12 +: 12] <= spr_rom[i][spr_addr[i*AW +: AW]];
    bg_color <= bg_rom(int'(bg_addr));
  end

  function automatic bit in_spr(input int i, input int h, input int v);
    return sh_en[i] && h >= sh_x[i] && h < sh_x[i] + 14 && v >= sh_y[i] && v < sh_y[i] + 16;
  endfunction

  function automatic logic [11:0] spr_px(input int i, input int h, input int v);
    return spr_rom[i][((v - sh_y[i]) * 14 + (h - sh_x[i])) % 256];
  endfunction

  function automatic bit opq(input int i, input int h, input int v);
    return in_spr(i, h, v) && spr_px(i, h, v) != KEY;
  endfunction

  function automatic logic [11:0] expect_rgb(input int h, input int v);
    for (int i = 0; i < N; i++) if (opq(i, h, v)) return spr_px(i, h, v);
    if (h >= 200 && h < 360 && v >= 150 && v < 390)
      return bg_rom((h - 200) + ((v - 150 + off) % 240) * 160);
    return 12'h000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic mreset();
    off = 0; cyc = 0; acc = '0; mcol = '0;
    for (int i = 0; i < N; i++) begin sh_x[i] = 0; sh_y[i] = 0; sh_en[i] = 0; end
    q.delete();
    q.push_back(12'h000);
    q.push_back(12'h000);
  endtask

  task automatic fill();
    for (int i = 0; i < N; i++)
      for (int a = 0; a < 256; a++)
        spr_rom[i][a] = ($urandom_range(3) == 0) ? KEY : 12'($urandom);
  endtask

  task automatic set_spr(input int i, input int x, input int y, input bit en);
    spr_x[i*PW +: PW] = PW'(x);
    spr_y[i*PW +: PW] = PW'(y);
    spr_en[i] = en;
  endtask

  task automatic step(input int h, input int v, input bit fs);
    hor = PW'(h); ver = PW'(v); frame_start = fs;
    q.push_back(expect_rgb(h, v));
    for (int i = 1; i < N; i++) if (opq(0, h, v) && opq(i, h, v)) acc[i-1] = 1'b1;
    @(posedge clk);
    if (cyc % 4 == 3 && scroll_en) off = (off + 239) % 240;
    cyc++;
    if (fs) begin
      mcol = acc; acc = '0;
      for (int i = 0; i < N; i++) begin
        sh_x[i] = int'(spr_x[i*PW +: PW]); sh_y[i] = int'(spr_y[i*PW +: PW]); sh_en[i] = spr_en[i];
      end
    end
    @(negedge clk);
    frame_start = 1'b0;
    chk("rgb", 32'(rgb), 32'(q.pop_front()));
    chk("bg_offset", 32'(bg_offset), 32'(off));
    chk("collide", 32'(collide), 32'(mcol));
  endtask

  task automatic frame();
    step(1000, 1000, 0);
    step(1000, 1000, 0);
    step(1000, 1000, 1);
  endtask

  initial begin
    hor = PW'(1000); ver = PW'(1000); frame_start = 1'b0; scroll_en = 1'b1;
    spr_x = '0; spr_y = '0; spr_en = '0;
    fill();
    mreset();
    repeat (2) @(negedge clk);
    chk("rst_rgb", 32'(rgb), 0);
    chk("rst_offset", 32'(bg_offset), 0);
    chk("rst_bg_addr", 32'(bg_addr), 0);
    chk("rst_spr_addr", 32'(spr_addr), 0);
    rst = 1'b0;
    // scroll from offset 0 with a 4-cycle divider
    repeat (4) step(1000, 1000, 0);
    chk("t4_off239", 32'(bg_offset), 239);
    step(200, 150, 0);
    chk("t4_bg_addr", 32'(bg_addr), 239 * 160);
    repeat (3) step(1000, 1000, 0);
    chk("t4_off238", 32'(bg_offset), 238);
    scroll_en = 1'b0;
    repeat (12) step(1000, 1000, 0);
    chk("t4_frozen", 32'(bg_offset), 238);
    // single sprite latency and addressing
    set_spr(0, 270, 300, 1);
    frame();
    spr_rom[0][0] = 12'h0F0;
    step(270, 300, 0);
    step(1000, 1000, 0);
    step(1000, 1000, 0);
    chk("t2_rgb", 32'(rgb), 32'h0F0);
    step(283, 315, 0);
    chk("t2_spr_addr", 32'(spr_addr[AW-1:0]), 223);
    // position change only takes effect at the next frame
    set_spr(0, 400, 300, 1);
    step(270, 300, 0);
    step(1000, 1000, 0);
    step(1000, 1000, 0);
    chk("t5_old_pos", 32'(rgb), 32'h0F0);
    frame();
    step(270, 300, 0);
    step(404, 301, 0);
    // keyed priority and collision
    set_spr(0, 250, 200, 1);
    set_spr(1, 250, 200, 1);
    set_spr(2, 0, 0, 0);
    set_spr(3, 0, 0, 0);
    frame();
    spr_rom[0][0] = KEY; spr_rom[1][0] = 12'h123;
    spr_rom[0][1] = 12'h456; spr_rom[1][1] = 12'h789;
    step(250, 200, 0);
    step(251, 200, 0);
    step(1000, 1000, 0);
    chk("t3_key", 32'(rgb), 32'h123);
    step(1000, 1000, 0);
    chk("t3_prio", 32'(rgb), 32'h456);
    frame();
    chk("t3_collide", 32'(collide[0]), 1);
    // sprite near the right edge must not wrap to x=0..9
    set_spr(0, 0, 0, 0);
    set_spr(1, 0, 0, 0);
    set_spr(2, 1020, 400, 1);
    frame();
    for (int h = 0; h < 10; h++) step(h, 405, 0);
    // randomized frames
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < N; i++)
        set_spr(i, $urandom_range(240, 300), $urandom_range(190, 250), $urandom_range(3) != 0);
      scroll_en = 1'($urandom);
      frame();
      fill();
      repeat (80) step($urandom_range(230, 330), $urandom_range(180, 290), 0);
    end
    // reset in the middle of the stream
    repeat (5) step($urandom_range(240, 300), $urandom_range(190, 250), 0);
    #2 rst = 1'b1;
    #1;
    chk("t1_rgb", 32'(rgb), 0);
    chk("t1_collide", 32'(collide), 0);
    chk("t1_offset", 32'(bg_offset), 0);
    hor = PW'(1000); ver = PW'(1000);
    repeat (2) @(negedge clk);
    chk("t1_hold_rgb", 32'(rgb), 0);
    chk("t1_hold_offset", 32'(bg_offset), 0);
    rst = 1'b0;
    mreset();
    scroll_en = 1'b1;
    set_spr(0, 260, 210, 1);
    set_spr(1, 262, 212, 1);
    frame();
    fill();
    repeat (60) step($urandom_range(255, 280), $urandom_range(205, 230), 0);
    frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
